// File: rtl/mbgd_hyp_stream.sv
// Streaming logistic-regression hypothesis unit: time-multiplexed dot product, saturation, PLAN sigmoid.
// Optional bias term is enabled by defining MBGD_HYP_BIAS_EN.
module mbgd_hyp_stream #(
    parameter int DW    = 8,
    parameter int FB    = 4,
    parameter int N     = 8,
    parameter int LANES = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            enable,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW*N-1:0] x,
    input  logic [DW*N-1:0] teta,
    input  logic [DW-1:0]   bias,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   h
);

    localparam int ACCW = 2*DW + $clog2(N) + 1;
    localparam int C    = (N + LANES - 1) / LANES;
    localparam int CW   = (C > 1) ? $clog2(C) : 1;
    localparam int IW   = (N > 1) ? $clog2(N) : 1;
    localparam int PW   = 2*DW;
    localparam int YW   = 2*DW + 2;

    localparam logic signed [ACCW-1:0] Z_MAX = ACCW'((2**(DW-1)) - 1);
    localparam logic signed [ACCW-1:0] Z_MIN = ~Z_MAX;

    // Breakpoints 1.0, 2.375 and 5.0 expressed in Q.FB
    localparam logic [DW:0] T_1 = (DW+1)'(1 << FB);
    localparam logic [DW:0] T_2 = (DW+1)'(19 << (FB-3));
    localparam logic [DW:0] T_5 = (DW+1)'(5 << FB);

    localparam logic [YW-1:0] Y_ONE = YW'(1) << DW;
    localparam logic [YW-1:0] Y_MAX = Y_ONE - YW'(1);
    localparam logic [YW-1:0] K_3   = YW'(27) << (DW-5);
    localparam logic [YW-1:0] K_2   = YW'(5) << (DW-3);
    localparam logic [YW-1:0] K_1   = YW'(1) << (DW-1);

    typedef enum logic [1:0] {IDLE, ACC, ACT, OUT} state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt;
    logic signed [ACCW-1:0] acc, acc_init, beat_sum;
    logic signed [DW-1:0]   x_r    [N];
    logic signed [DW-1:0]   teta_r [N];
    logic [DW-1:0]          h_nxt;
    logic                   last_beat;

    assign in_ready  = enable && (state == IDLE);
    assign out_valid = enable && (state == OUT);
    assign last_beat = (cnt == CW'(C-1));

`ifdef MBGD_HYP_BIAS_EN
    assign acc_init = ACCW'($signed(bias)) <<< FB;
`else
    // Bias is ignored in this build; the term folds to zero and leaves no register.
    assign acc_init = ACCW'(bias) & '0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        // NOTE: every combinational output is given a default first so no latch is inferred.
        state_nxt = state;
        if (enable) begin
            unique case (state)
                IDLE: if (in_valid)  state_nxt = ACC;
                ACC:  if (last_beat) state_nxt = ACT;
                ACT:                 state_nxt = OUT;
                OUT:  if (out_ready) state_nxt = IDLE;
                default:             state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        int                   raw;
        logic [IW-1:0]        idx;
        logic signed [PW-1:0] prod;
        beat_sum = '0;
        raw      = 0;
        idx      = '0;
        prod     = '0;
        for (int j = 0; j < LANES; j++) begin
            raw = int'(cnt) * LANES + j;
            idx = IW'(raw);
            if (raw < N) begin
                prod     = x_r[idx] * teta_r[idx];
                beat_sum = beat_sum + ACCW'(prod);
            end
        end
    end

    always_comb begin
        logic signed [ACCW-1:0] zs;
        logic signed [DW-1:0]   z;
        logic [DW:0]            a;
        logic [YW-1:0]          as_, y_s;
        zs = acc >>> FB;
        if (zs > Z_MAX)      z = Z_MAX[DW-1:0];
        else if (zs < Z_MIN) z = Z_MIN[DW-1:0];
        else                 z = zs[DW-1:0];
        a   = z[DW-1] ? -{1'b1, z} : {1'b0, z};
        as_ = YW'(a) << (DW-FB);
        if (a >= T_5)      y_s = Y_ONE;
        else if (a >= T_2) y_s = (as_ >> 5) + K_3;
        else if (a >= T_1) y_s = (as_ >> 3) + K_2;
        else               y_s = (as_ >> 2) + K_1;
        if (!z[DW-1]) h_nxt = DW'((y_s > Y_MAX) ? Y_MAX : y_s);
        else          h_nxt = DW'((y_s >= Y_ONE) ? '0 : (Y_ONE - y_s));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc <= '0;
            cnt <= '0;
            h   <= '0;
        end else if (enable) begin
            unique case (state)
                IDLE: if (in_valid) begin
                    acc <= acc_init;
                    cnt <= '0;
                end
                ACC: begin
                    acc <= acc + beat_sum;
                    cnt <= cnt + CW'(1);
                end
                ACT:     h <= h_nxt;
                default: ;
            endcase
        end
    end

    // NOTE: the sample registers are pure datapath, loaded before any read, so they carry no reset.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            for (int i = 0; i < N; i++) begin
                x_r[i]    <= x[DW*i +: DW];
                teta_r[i] <= teta[DW*i +: DW];
            end
        end
    end

endmodule

// File: tb/tb_mbgd_hyp_stream.sv
// Scoreboard bench for mbgd_hyp_stream at default parameters; bias case follows MBGD_HYP_BIAS_EN.
module tb_mbgd_hyp_stream;

    localparam int DW = 8;
    localparam int N  = 8;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            enable = 1'b1;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b1;
    logic [DW*N-1:0] x = '0;
    logic [DW*N-1:0] teta = '0;
    logic [DW-1:0]   bias = '0;
    logic            in_ready, out_valid;
    logic [DW-1:0]   h;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    mbgd_hyp_stream #(.DW(DW), .FB(4), .N(N), .LANES(4)) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .teta(teta), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .h(h)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, want);
        end
    endtask

    function automatic logic [63:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a sample, wait (bounded) for acceptance, then scramble the bus.
    task automatic offer(input logic [63:0] xv, input logic [63:0] tv);
        int n;
        n = 0;
        x = xv; teta = tv; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; x = ~xv; teta = ~tv;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // Monitor: compare every output handshake against the scoreboard.
    initial begin
        logic [DW-1:0] want;
        forever begin
            @(negedge clk);
            if (resetn && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    want = exp_q.pop_front();
                    check("h", h, want);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    logic [63:0] vx [14] = '{
        64'h0, rep(8'h10), rep(8'h7F), rep(8'h7F), 64'h00000000_10101010,
        64'h10101010_00000000, 64'h00000000_10101010, 64'h00000000_10101010,
        64'h01, 64'h26, 64'h25, 64'h4F, 64'h10, 64'h0F};
    logic [63:0] vt [14] = '{
        rep(8'h55), rep(8'hF8), rep(8'h7F), rep(8'h80), rep(8'h10),
        rep(8'h18), 64'h00000000_06060606, 64'h00000000_FAFAFAFA,
        64'hFF, 64'h10, 64'h10, 64'hF0, 64'h10, 64'h10};
    logic [7:0]  ve [14] = '{
        8'h80, 8'h08, 8'hFF, 8'h00, 8'hF8,
        8'hFF, 8'hD0, 8'h30,
        8'h7C, 8'hEB, 8'hEA, 8'h01, 8'hC0, 8'hBC};

    initial begin
        int n;
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_h", h, 8'h00);
        resetn = 1'b1;
        tick();

        // Basic result and latency
        exp_q.push_back(8'hF8);
        offer(rep(8'h10), rep(8'h08));
        wait_out(n);
        check("latency", n, 3);
        check("busy_in_ready", in_ready, 1'b0);
        drain();

        // Directed vectors, including band edges and floor rounding
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(ve[i]);
            offer(vx[i], vt[i]);
        end
        drain();

        // Backpressure with a second sample waiting
        out_ready = 1'b0;
        exp_q.push_back(8'hF8);
        offer(rep(8'h10), rep(8'h08));
        wait_out(n);
        exp_q.push_back(8'h80);
        x = '0; teta = rep(8'h33); in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_h", h, 8'hF8);
            check("bp_in_ready", in_ready, 1'b0);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_at_out", in_ready, 1'b0);
        @(negedge clk);
        check("bp_in_ready_after_out", in_ready, 1'b1);
        tick();
        in_valid = 1'b0; x = rep(8'hAA); teta = rep(8'h55);
        drain();

        // Stall in ACC for three cycles
        exp_q.push_back(8'hF8);
        offer(rep(8'h10), rep(8'h08));
        tick();
        enable = 1'b0;
        n = 1;
        repeat (3) begin
            tick();
            n++;
            check("stall_out_valid", out_valid, 1'b0);
        end
        enable = 1'b1;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check("stall_latency", n, 6);
        enable = 1'b0;
        #1;
        check("gated_out_valid", out_valid, 1'b0);
        check("gated_h", h, 8'hF8);
        tick();
        enable = 1'b1;
        drain();

        tick();
        enable = 1'b0;
        #1;
        check("gated_in_ready", in_ready, 1'b0);
        enable = 1'b1;
        #1;
        check("idle_in_ready", in_ready, 1'b1);

        // Reset during ACC discards the sample
        offer(rep(8'h10), rep(8'h08));
        tick();
        resetn = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_h", h, 8'h00);
        #2;
        resetn = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("no_out_after_rst", out_valid, 1'b0);
        end
        check("post_rst_in_ready", in_ready, 1'b1);
        tick();

        // Bias term
        bias = 8'h10;
`ifdef MBGD_HYP_BIAS_EN
        exp_q.push_back(8'hC0);
`else
        exp_q.push_back(8'h80);
`endif
        offer(64'h0, rep(8'h40));
        bias = 8'h00;
        drain();

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
